// File: rtl/guvm_cache_responder.sv
// Instruction/data cache response model for the core-level GUVM bench.
// Icache serves words from a driver-fed queue; dcache is a small word memory.
module guvm_cache_responder #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int IQ_DEPTH      = 16,
    parameter int DMEM_WORDS    = 64,
    parameter int EMPTY_TIMEOUT = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0100_0000)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic [DATA_W-1:0]             inst_data,
    input  logic [3:0]                    cfg_iwait,
    input  logic [3:0]                    cfg_dwait,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic [DATA_W-1:0]             ic_data,
    output logic                          ic_hold,
    output logic [ADDR_W-1:0]             ic_resp_addr,
    output logic                          ic_underflow,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic [DATA_W-1:0]             dc_data,
    output logic                          dc_hold,
    output logic                          dc_mexc,
    output logic                          dc_werr,
    output logic                          st_valid,
    output logic [ADDR_W-1:0]             st_addr,
    output logic [DATA_W-1:0]             st_data,
    output logic [$clog2(IQ_DEPTH):0]     iq_count
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DMEM_WORDS);
    localparam int TW = $clog2(EMPTY_TIMEOUT + 1);

    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_STARVE, I_RESP} istate_t;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} dstate_t;

    // ---------------- instruction queue ----------------
    logic [DATA_W-1:0] iq_mem [IQ_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     cnt_q;
    logic              iq_full, iq_empty, push, pop;

    istate_t           ist, ist_n;
    logic              inop_q, inop_n;

    assign iq_full    = (cnt_q == CW'(IQ_DEPTH));
    assign iq_empty   = (cnt_q == '0);
    assign pop        = (ist == I_RESP) && !inop_q;
    // a pop frees a slot in the same cycle, so a full queue can still accept
    assign inst_ready = !iq_full || pop;
    assign push       = inst_valid && inst_ready;
    assign iq_count   = cnt_q;

    always_ff @(posedge clk) begin
        if (push) iq_mem[wptr] <= inst_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- icache FSM ----------------
    logic [3:0]        icnt, icnt_n;
    logic [TW-1:0]     itmr, itmr_n;
    logic [ADDR_W-1:0] iaddr_q, iaddr_n;
    logic [DATA_W-1:0] ic_word, ic_data_q;
    logic [ADDR_W-1:0] ic_raddr_q;

    assign ic_word = inop_q ? NOP_WORD : iq_mem[rptr];

    always_comb begin
        ist_n   = ist;
        icnt_n  = icnt;
        itmr_n  = itmr;
        inop_n  = inop_q;
        iaddr_n = iaddr_q;
        unique case (ist)
            I_IDLE: begin
                if (ic_req) begin
                    iaddr_n = ic_addr;
                    icnt_n  = cfg_iwait;
                    itmr_n  = '0;
                    inop_n  = 1'b0;
                    if (cfg_iwait != 4'd0) ist_n = I_WAIT;
                    else if (iq_empty)     ist_n = I_STARVE;
                    else                   ist_n = I_RESP;
                end
            end
            I_WAIT: begin
                icnt_n = icnt - 4'd1;
                if (icnt == 4'd1) ist_n = iq_empty ? I_STARVE : I_RESP;
            end
            I_STARVE: begin
                if (!iq_empty) begin
                    ist_n = I_RESP;
                end else if (itmr == TW'(EMPTY_TIMEOUT - 1)) begin
                    ist_n  = I_RESP;
                    inop_n = 1'b1;
                end else begin
                    itmr_n = itmr + TW'(1);
                end
            end
            I_RESP:  ist_n = I_IDLE;
            default: ist_n = I_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ist        <= I_IDLE;
            icnt       <= '0;
            itmr       <= '0;
            inop_q     <= 1'b0;
            iaddr_q    <= '0;
            ic_data_q  <= '0;
            ic_raddr_q <= '0;
        end else begin
            ist     <= ist_n;
            icnt    <= icnt_n;
            itmr    <= itmr_n;
            inop_q  <= inop_n;
            iaddr_q <= iaddr_n;
            if (ist == I_RESP) begin
                ic_data_q  <= ic_word;
                ic_raddr_q <= iaddr_q;
            end
        end
    end

    assign ic_hold      = !((ist == I_WAIT) || (ist == I_STARVE));
    assign ic_data      = (ist == I_RESP) ? ic_word : ic_data_q;
    assign ic_resp_addr = (ist == I_RESP) ? iaddr_q : ic_raddr_q;
    assign ic_underflow = (ist == I_RESP) && inop_q;

    // ---------------- dcache FSM ----------------
    dstate_t           dst, dst_n;
    logic [3:0]        dcnt, dcnt_n;
    logic              dwe_q, dwe_n;
    logic [ADDR_W-1:0] daddr_q, daddr_n;
    logic [DATA_W-1:0] dwdata_q, dwdata_n;
    logic [DATA_W-1:0] dmem [DMEM_WORDS];
    logic [DW-1:0]     d_idx;
    logic              d_bad, in_dresp;
    logic [DATA_W-1:0] d_load, dc_data_q, st_data_q;
    logic [ADDR_W-1:0] st_addr_q;

    assign d_idx    = daddr_q[DW+1:2];
    assign d_bad    = (|daddr_q[1:0]) || (|daddr_q[ADDR_W-1:DW+2]);
    assign in_dresp = (dst == D_RESP);
    assign d_load   = d_bad ? '0 : dmem[d_idx];

    always_comb begin
        dst_n    = dst;
        dcnt_n   = dcnt;
        dwe_n    = dwe_q;
        daddr_n  = daddr_q;
        dwdata_n = dwdata_q;
        unique case (dst)
            D_IDLE: begin
                if (dc_req) begin
                    dwe_n    = dc_we;
                    daddr_n  = dc_addr;
                    dwdata_n = dc_wdata;
                    dcnt_n   = cfg_dwait;
                    dst_n    = (cfg_dwait != 4'd0) ? D_WAIT : D_RESP;
                end
            end
            D_WAIT: begin
                dcnt_n = dcnt - 4'd1;
                if (dcnt == 4'd1) dst_n = D_RESP;
            end
            D_RESP:  dst_n = D_IDLE;
            default: dst_n = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst       <= D_IDLE;
            dcnt      <= '0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dc_data_q <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
        end else begin
            dst      <= dst_n;
            dcnt     <= dcnt_n;
            dwe_q    <= dwe_n;
            daddr_q  <= daddr_n;
            dwdata_q <= dwdata_n;
            if (in_dresp && !dwe_q) dc_data_q <= d_load;
            if (st_valid) begin
                st_addr_q <= daddr_q;
                st_data_q <= dwdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else if (st_valid) begin
            dmem[d_idx] <= dwdata_q;
        end
    end

    assign dc_hold  = (dst != D_WAIT);
    assign dc_mexc  = in_dresp && !dwe_q && d_bad;
    assign dc_werr  = in_dresp && dwe_q && d_bad;
    assign st_valid = in_dresp && dwe_q && !d_bad;
    assign dc_data  = (in_dresp && !dwe_q) ? d_load : dc_data_q;
    assign st_addr  = st_valid ? daddr_q : st_addr_q;
    assign st_data  = st_valid ? dwdata_q : st_data_q;

endmodule

// File: doc/guvm_cache_responder.md
Name: guvm_cache_responder

Overview:
- Parametrised instruction- and data-cache response model for the core-level GUVM bench.
- Stands in place of the static icache/dcache output ties.
- The instruction side returns words from a driver-fed queue, with programmable wait states and an underflow NOP fill.
- The data side is a small word-addressed memory with wait states, error flags and a store-capture port for the monitor.

Parameters:
DATA_W, 32, instruction/data word width
ADDR_W, 32, core address width
IQ_DEPTH, 16, instruction queue depth (power of 2, >=2)
DMEM_WORDS, 64, data memory size in words (power of 2)
EMPTY_TIMEOUT, 8, cycles stalled on an empty queue before NOP fill
NOP_WORD, 32'h01000000, instruction returned on underflow

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
inst_valid  in  1  driver pushes inst_data
inst_ready  out  1  queue not full
inst_data  in  DATA_W  instruction to enqueue
cfg_iwait  in  4  icache wait states, sampled at request accept
cfg_dwait  in  4  dcache wait states, sampled at request accept
ic_req  in  1  fetch request, one-cycle pulse
ic_addr  in  ADDR_W  fetch address (echoed on ic_resp_addr only)
ic_data  out  DATA_W  fetched instruction
ic_hold  out  1  active-low stall: 0 = core must wait
ic_resp_addr  out  ADDR_W  address of the current response
ic_underflow  out  1  one-cycle pulse when NOP fill is issued
dc_req  in  1  data access request, one-cycle pulse
dc_we  in  1  1 = store, 0 = load
dc_addr  in  ADDR_W  byte address
dc_wdata  in  DATA_W  store data
dc_data  out  DATA_W  load data
dc_hold  out  1  active-low stall
dc_mexc  out  1  load error pulse
dc_werr  out  1  store error pulse
st_valid  out  1  store-capture pulse for the monitor
st_addr  out  ADDR_W  captured store address
st_data  out  DATA_W  captured store data
iq_count  out  $clog2(IQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset values:
  - ic_hold=1, dc_hold=1; ic_data, dc_data, ic_resp_addr, st_addr, st_data = 0.
  - All pulse outputs = 0; iq_count = 0; inst_ready = 1.
  - Queue flushed; data memory cleared to 0; both FSMs go to IDLE.
  - Reset mid-transaction aborts the transaction with no response and no write.
- Queue:
  - A push occurs when inst_valid && inst_ready.
  - A push and a pop in the same cycle are both allowed when full, and also when empty and bypass does not apply. Occupancy is unchanged.
  - Pointers wrap modulo IQ_DEPTH.
  - A push while full is dropped; inst_ready is 0 in that case, so the drop is driver misuse.
- Icache FSM states: IDLE, WAIT, STARVE, RESP.
  - IDLE: ic_req at cycle N latches ic_addr and cnt=cfg_iwait.
    - cnt>0 -> WAIT.
    - cnt=0 -> RESP, or STARVE if the queue is empty.
  - WAIT: ic_hold=0. cnt decrements each cycle. At cnt=1 -> RESP, or STARVE if empty at that edge.
  - STARVE: ic_hold=0; timer counts.
    - A word arriving -> RESP on the next edge.
    - Timer reaching EMPTY_TIMEOUT -> RESP with NOP_WORD and ic_underflow=1 for that RESP cycle.
  - RESP: one cycle.
    - ic_hold=1, ic_data = queue head (or NOP); the queue pops, except on NOP.
    - ic_resp_addr = latched address. Next state IDLE.
  - ic_data and ic_resp_addr hold their last value outside RESP.
  - Latency: with cfg_iwait=W and the queue non-empty, the response is in cycle N+1+W. ic_hold is 0 during N+1..N+W.
  - ic_req while not in IDLE is ignored.
- Dcache FSM states: IDLE, WAIT, RESP. Same timing as the icache using cfg_dwait; there is no STARVE state.
  - Word index = dc_addr[$clog2(DMEM_WORDS)+1:2].
  - An address is illegal if dc_addr[1:0]!=0 or any bit above the index is set.
  - RESP load, legal: dc_data = mem[index].
  - RESP load, illegal: dc_mexc=1, dc_data=0.
  - RESP store, legal: mem[index] = latched wdata; st_valid=1; st_addr/st_data = latched values.
  - RESP store, illegal: dc_werr=1, no write, st_valid=0.
  - Request fields are latched at accept; later input changes have no effect.
- The two FSMs are independent. Simultaneous ic_req and dc_req are both accepted.

Test Plan:
1. Reset, push 0x8E00C002 and 0x01000000, cfg_iwait=0, ic_req at cycle 10 -> ic_hold stays 1; ic_data=0x8E00C002 at cycle 11; iq_count 2->1.
2. cfg_iwait=3, queue non-empty, ic_req at N -> ic_hold=0 in N+1..N+3; ic_hold=1 with data at N+4; ic_resp_addr equals the request address.
3. Queue empty, ic_req, no pushes -> ic_hold=0 until timeout; NOP_WORD returned with ic_underflow=1, exactly 8 cycles after the STARVE state is entered; iq_count stays 0.
4. Fill 16 words -> inst_ready=0. Then push and pop in the same cycle -> iq_count stays 16, and FIFO order is preserved across the pointer wrap.
5. cfg_dwait=1: store 0xDEADBEEF to 0x10, then load 0x10 -> st_valid pulse with st_addr=0x10; load returns 0xDEADBEEF in the second cycle after its request.
6. Load at 0x2 -> dc_mexc=1, dc_data=0. Store to 0x400 -> dc_werr=1, no st_valid. Asserting rst during a dcache WAIT -> no response, and a following load at that address returns 0.
